split_slave_ctrl: RTL and testbench

- Slave-side controller for slow (split-capable) bus slaves.
- Decides per transaction whether to serve the master directly or split the bus:
  - direct service if the memory answers within SPLIT_THRESH cycles;
  - otherwise raises SBSY to the bus arbiter, tracks the split master and requests resume once data is ready.
- Sits between the address decoder / bus arbiter and the slave memory core; one instance per split-capable slave.

---
 rtl/split_slave_ctrl.sv | 167 ++++++++++++++++
 tb/tb_split_slave_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/split_slave_ctrl.sv
// split_slave_ctrl: slave-side controller for a split-capable bus slave.
// Each transaction is either served directly, when the memory core answers
// within SPLIT_THRESH cycles of MEM_START, or split: the slave raises SBSY,
// remembers the owning master and requests a resume once the data is ready.
// All outputs are registered, so no input reaches an output combinationally.
module split_slave_ctrl #(
    parameter int SPLIT_THRESH = 4,
    parameter int TIMEOUT_CYC  = 64,
    parameter int CNT_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       SEL,
    input  logic [1:0] B_GRANT,
    input  logic       B_UTIL,
    input  logic       B_DONE,
    input  logic       B_SPL_RESUME,
    input  logic       MEM_READY,
    output logic       MEM_START,
    output logic       SBSY,
    output logic [1:0] SPL_MASTER,
    output logic       SPL_READY,
    output logic       SLV_READY,
    output logic       ERR
);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_ACCESS      = 3'd1;
    localparam logic [2:0] ST_SERVE       = 3'd2;
    localparam logic [2:0] ST_SPLIT_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESUME_WAIT = 3'd4;

    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(SPLIT_THRESH);
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_SAT_C  = CNT_W'(TIMEOUT_CYC);

    // Saturating increment: the cycle counter never wraps.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        if (c < TO_SAT_C) begin
            return c + CNT_W'(1);
        end else begin
            return c;
        end
    endfunction

    logic [2:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             mem_start_r, mem_start_s;
    logic             sbsy_r, sbsy_s;
    logic [1:0]       master_r, master_s;
    logic             spl_ready_r, spl_ready_s;
    logic             slv_ready_r, slv_ready_s;
    logic             err_r, err_s;
    logic             start_s;

    assign start_s = SEL & B_UTIL & ((B_GRANT == 2'b01) | (B_GRANT == 2'b10));

    // Next-state and next-output decision for the transaction FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mem_start_s = 1'b0;
        err_s       = 1'b0;
        sbsy_s      = sbsy_r;
        master_s    = master_r;
        spl_ready_s = spl_ready_r;
        slv_ready_s = slv_ready_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s     = ST_ACCESS;
                    master_s    = B_GRANT;
                    mem_start_s = 1'b1;
                    cnt_s       = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // While MEM_START is still high, MEM_READY may be the stale
                // level of the previous access, so it is not trusted yet.
                if (!mem_start_r && MEM_READY) begin
                    state_s     = ST_SERVE;
                    slv_ready_s = 1'b1;
                end else if (cnt_r == THRESH_C) begin
                    state_s = ST_SPLIT_WAIT;
                    sbsy_s  = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_inc(cnt_r);
                end
            end
            ST_SPLIT_WAIT: begin
                if (MEM_READY) begin
                    state_s     = ST_RESUME_WAIT;
                    spl_ready_s = 1'b1;
                end else if (cnt_r == TO_LAST_C) begin
                    state_s  = ST_IDLE;
                    err_s    = 1'b1;
                    sbsy_s   = 1'b0;
                    master_s = 2'b00;
                    cnt_s    = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_inc(cnt_r);
                end
            end
            ST_RESUME_WAIT: begin
                if (B_SPL_RESUME && (B_GRANT == master_r)) begin
                    state_s     = ST_SERVE;
                    sbsy_s      = 1'b0;
                    spl_ready_s = 1'b0;
                    slv_ready_s = 1'b1;
                end else begin
                    state_s = ST_RESUME_WAIT;
                end
            end
            ST_SERVE: begin
                if (B_DONE) begin
                    state_s     = ST_IDLE;
                    slv_ready_s = 1'b0;
                    master_s    = 2'b00;
                end else begin
                    state_s = ST_SERVE;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = {CNT_W{1'b0}};
                sbsy_s      = 1'b0;
                master_s    = 2'b00;
                spl_ready_s = 1'b0;
                slv_ready_s = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            mem_start_r <= 1'b0;
            sbsy_r      <= 1'b0;
            master_r    <= 2'b00;
            spl_ready_r <= 1'b0;
            slv_ready_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            mem_start_r <= mem_start_s;
            sbsy_r      <= sbsy_s;
            master_r    <= master_s;
            spl_ready_r <= spl_ready_s;
            slv_ready_r <= slv_ready_s;
            err_r       <= err_s;
        end
    end

    assign MEM_START  = mem_start_r;
    assign SBSY       = sbsy_r;
    assign SPL_MASTER = master_r;
    assign SPL_READY  = spl_ready_r;
    assign SLV_READY  = slv_ready_r;
    assign ERR        = err_r;

endmodule

// File: tb/tb_split_slave_ctrl.sv
// Testbench for split_slave_ctrl: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic, all checked against a
// transaction-phase reference model.
module tb_split_slave_ctrl;

    localparam int THRESH  = 4;
    localparam int TIMEOUT = 64;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       SEL = 1'b0;
    logic [1:0] B_GRANT = 2'b00;
    logic       B_UTIL = 1'b0;
    logic       B_DONE = 1'b0;
    logic       B_SPL_RESUME = 1'b0;
    logic       MEM_READY = 1'b0;
    logic       MEM_START, SBSY, SPL_READY, SLV_READY, ERR;
    logic [1:0] SPL_MASTER;

    int n_checks = 0;
    int n_fail   = 0;

    split_slave_ctrl #(.SPLIT_THRESH(THRESH), .TIMEOUT_CYC(TIMEOUT)) dut (
        .CLK(CLK), .RSTN(RSTN), .SEL(SEL), .B_GRANT(B_GRANT), .B_UTIL(B_UTIL),
        .B_DONE(B_DONE), .B_SPL_RESUME(B_SPL_RESUME), .MEM_READY(MEM_READY),
        .MEM_START(MEM_START), .SBSY(SBSY), .SPL_MASTER(SPL_MASTER),
        .SPL_READY(SPL_READY), .SLV_READY(SLV_READY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model: which phase the transaction is in and how many
    // clock edges it has spent there. Outputs follow from the phase.
    typedef enum int {P_IDLE, P_ACCESS, P_SPLIT, P_RESUME, P_SERVE} phase_t;
    phase_t m_phase = P_IDLE;
    int         m_age = 0;
    logic [1:0] m_owner = 2'b00;
    logic       m_ms = 1'b0;
    logic       m_err = 1'b0;

    function automatic logic [6:0] model_vec();
        logic busy;
        busy = (m_phase == P_SPLIT) || (m_phase == P_RESUME);
        return {m_ms, busy, m_owner, (m_phase == P_RESUME), (m_phase == P_SERVE), m_err};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {MEM_START, SBSY, SPL_MASTER, SPL_READY, SLV_READY, ERR};
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_age = 0; m_owner = 2'b00; m_ms = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic good_grant;
        good_grant = (B_GRANT == 2'b01) || (B_GRANT == 2'b10);
        m_ms  = 1'b0;
        m_err = 1'b0;
        case (m_phase)
            P_IDLE: if (SEL && B_UTIL && good_grant) begin
                m_phase = P_ACCESS; m_age = 0; m_owner = B_GRANT; m_ms = 1'b1;
            end
            P_ACCESS: begin
                m_age++;
                // the MEM_START cycle itself carries no fresh answer
                if (m_age >= 2 && MEM_READY) m_phase = P_SERVE;
                else if (m_age == THRESH + 1) begin m_phase = P_SPLIT; m_age = 0; end
            end
            P_SPLIT: begin
                m_age++;
                if (MEM_READY) m_phase = P_RESUME;
                else if (m_age == TIMEOUT) begin
                    m_phase = P_IDLE; m_owner = 2'b00; m_err = 1'b1;
                end
            end
            P_RESUME: if (B_SPL_RESUME && B_GRANT == m_owner) m_phase = P_SERVE;
            P_SERVE: if (B_DONE) begin m_phase = P_IDLE; m_owner = 2'b00; end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_vec(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {ms,sbsy,mst,splr,slvr,err}=%b, expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs (at the negative edge), clock one rising edge, update the
    // model and return at the next negative edge for sampling.
    task automatic apply(input logic sel, input logic util, input logic [1:0] gnt,
                         input logic done, input logic res, input logic rdy);
        SEL = sel; B_UTIL = util; B_GRANT = gnt; B_DONE = done;
        B_SPL_RESUME = res; MEM_READY = rdy;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic idle_step(input logic rdy);
        apply(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, rdy);
    endtask

    task automatic check_model(input string name);
        check_vec(name, dut_vec(), model_vec());
    endtask

    // Pulse RSTN low between clock edges and check the asynchronous clear.
    task automatic async_reset(input string name);
        #2 RSTN = 1'b0;
        #1 check_vec(name, dut_vec(), 7'b0);
        model_reset();
        #1 RSTN = 1'b1;
    endtask

    typedef struct {
        logic       sel, util;
        logic [1:0] gnt;
        logic       done, res, rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Directed table: M1 direct transaction, then illegal grants.
        // exp = {MEM_START, SBSY, SPL_MASTER, SPL_READY, SLV_READY, ERR}
        tbl[0] = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 7'b1_0_01_0_0_0};
        tbl[1] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b0_0_01_0_0_0};
        tbl[2] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b0_0_01_0_0_0};
        tbl[3] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 7'b0_0_01_0_1_0};
        tbl[4] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 7'b0_0_01_0_1_0};
        tbl[5] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 7'b0_0_01_0_1_0};
        tbl[6] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 7'b0_0_00_0_0_0};
        tbl[7] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b0_0_00_0_0_0};
        tbl[8] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 7'b0_0_00_0_0_0};
        tbl[9] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 7'b0_0_00_0_0_0};

        // Reset state
        repeat (2) @(negedge CLK);
        check_vec("reset_state", dut_vec(), 7'b0);
        RSTN = 1'b1;
        model_reset();
        idle_step(1'b0);
        check_vec("idle_after_reset", dut_vec(), 7'b0);

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].sel, tbl[i].util, tbl[i].gnt, tbl[i].done, tbl[i].res, tbl[i].rdy);
            check_vec($sformatf("table_row%0d", i), dut_vec(), tbl[i].exp);
        end

        // M2 split: SBSY rises SPLIT_THRESH+1 edges after the start edge
        apply(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        check_model("m2_start");
        for (int k = 1; k <= 10; k++) begin
            idle_step(k == 10);
            check_bit($sformatf("m2_sbsy_k%0d", k), SBSY, (k >= THRESH + 1));
            check_model($sformatf("m2_seq_k%0d", k));
        end
        check_bit("m2_spl_ready", SPL_READY, 1'b1);
        apply(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
        check_vec("m2_resumed", dut_vec(), 7'b0_0_10_0_1_0);
        apply(1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1);
        check_vec("m2_done", dut_vec(), 7'b0);

        // MEM_READY on the last allowed ACCESS edge: served directly
        apply(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= THRESH + 1; k++) idle_step(k == THRESH + 1);
        check_vec("thresh_direct", dut_vec(), 7'b0_0_01_0_1_0);
        apply(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        check_model("thresh_done");

        // Split by M1; M2 start ignored; mismatched resume ignored
        apply(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= THRESH + 1; k++) idle_step(1'b0);
        check_vec("m1_split", dut_vec(), 7'b0_1_01_0_0_0);
        apply(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        check_vec("m2_start_ignored", dut_vec(), 7'b0_1_01_0_0_0);
        idle_step(1'b1);
        check_vec("m1_data_ready", dut_vec(), 7'b0_1_01_1_0_0);
        apply(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
        check_vec("wrong_resume_ignored", dut_vec(), 7'b0_1_01_1_0_0);
        apply(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1);
        check_vec("right_resume", dut_vec(), 7'b0_0_01_0_1_0);
        apply(1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1);
        check_model("m1_done");

        // Timeout: ERR exactly TIMEOUT edges after SBSY rises
        apply(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= THRESH + 1; k++) idle_step(1'b0);
        check_bit("to_sbsy_up", SBSY, 1'b1);
        for (int k = 1; k <= TIMEOUT + 2; k++) begin
            apply(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
            if (k == TIMEOUT) check_vec("timeout_err", dut_vec(), 7'b0_0_00_0_0_1);
            else if (k == TIMEOUT + 1) check_vec("timeout_after", dut_vec(), 7'b0);
            else check_model($sformatf("timeout_k%0d", k));
        end

        // Async reset in SPLIT_WAIT, then fresh transaction
        apply(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= THRESH + 3; k++) idle_step(1'b0);
        async_reset("reset_in_split");
        apply(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        check_vec("fresh_start", dut_vec(), 7'b1_0_01_0_0_0);
        idle_step(1'b0);
        idle_step(1'b1);
        check_vec("fresh_serve", dut_vec(), 7'b0_0_01_0_1_0);
        async_reset("reset_in_serve");
        idle_step(1'b0);
        check_vec("idle_after_reset2", dut_vec(), 7'b0);

        // Randomized traffic with varying memory speed
        for (int seg = 0; seg < 6; seg++) begin
            int pct;
            pct = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 15 : 45);
            for (int c = 0; c < 400; c++) begin
                logic [1:0] g;
                g = 2'($urandom_range(0, 3));
                apply($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, g,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 99) < pct);
                check_model($sformatf("rand_s%0d_c%0d", seg, c));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
